// File: rtl/uart_rx_deserializer_if.sv
// Byte handshake between the UART receiver and whatever consumes its bytes.
// The receiver drives the holding register (rx_data/rx_valid) through the
// master modport; the consumer answers with rx_ready through the slave modport.
interface uart_rx_deserializer_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART receiver: oversamples the asynchronous rx line with a fixed divider,
// checks start and stop bits and presents each byte in a one-entry
// valid/ready holding register.
// Frame format is 8N1 by default; defining UART_RX_PARITY_EN switches to 8E1
// with a parity check (parity_err pulses, the byte is still delivered).
module uart_rx_deserializer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx,
  uart_rx_deserializer_if.master bus,
  output logic                   frame_err,
  output logic                   parity_err,
  output logic                   overrun,
  output logic                   busy
);

  localparam int N  = CLKS_PER_BIT;
  localparam int H  = N / 2;
  localparam int CW = $clog2(N);
  // Counter value on the last cycle of a full bit and of the half start bit.
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BRK
  } state_t;

  logic          rx_meta;
  logic          rx_s;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
`ifdef UART_RX_PARITY_EN
  logic          par_bit;
`endif

  // Two-flop synchronizer; flops reset to the idle (high) line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Frame FSM plus holding register; every output is registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      shift        <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit      <= 1'b0;
      parity_err   <= 1'b0;
`endif
      bus.rx_data  <= 8'h00;
      bus.rx_valid <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      // Handshake empties the register; a same-cycle delivery below overrides.
      if (bus.rx_valid && bus.rx_ready) begin
        bus.rx_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (cnt == CNT_HALF) begin
            if (rx_s) begin
              // Line went high again before mid start bit: treat as glitch.
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
              cnt   <= '0;
              idx   <= '0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            shift <= {rx_s, shift[7:1]};
            idx   <= idx + 3'd1;
            if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            par_bit <= rx_s;
            state   <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif

        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
`ifdef UART_RX_PARITY_EN
            // Even parity: parity bit must equal the XOR of the data bits.
            parity_err <= (par_bit != ^shift);
`endif
            if (rx_s) begin
              // Leave mid stop bit so the next start edge is not missed.
              state <= IDLE;
              busy  <= 1'b0;
              if (!bus.rx_valid || bus.rx_ready) begin
                bus.rx_data  <= shift;
                bus.rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= BRK;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        BRK: begin
          // Hold off until the line is released so a break flags only once.
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer. Frames are driven on the pin at N clocks per
// bit; each frame is turned into a scheduled result (byte or frame error, plus
// parity error) at a fixed latency, and a holding-register model applies those
// results and the ready handshake to predict the outputs every cycle.
module tb_uart_rx_deserializer;
  localparam int N = 16;
  localparam int H = N / 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PARITY_ON  = 1'b1;
  localparam int FRAME_BITS = 11;
`else
  localparam bit PARITY_ON  = 1'b0;
  localparam int FRAME_BITS = 10;
`endif
  // First low pin cycle c -> t0 = c+2; stop sample at t0+H+(FRAME_BITS-1)*N;
  // result visible one cycle later.
  localparam int LAT = 3 + H + (FRAME_BITS - 1) * N;

  logic clk = 1'b0;
  logic reset;
  logic rx;
  logic frame_err, parity_err, overrun, busy;
  logic ready_mode, ready_val, rnd_ready;

  uart_rx_deserializer_if bus ();

  assign bus.rx_ready = ready_mode ? rnd_ready : ready_val;

  uart_rx_deserializer #(.CLKS_PER_BIT(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .bus        (bus.master),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Scheduled results keyed by the cycle in which they must be visible.
  logic [7:0] ev_byte [int];
  bit         ev_ferr [int];
  bit         ev_perr [int];
  bit         exp_busy [int];

  // Observations for the directed literal checks.
  logic [7:0] got [$];
  int rises = 0, last_rise_cyc = -1;
  int ferr_cnt = 0, ovr_cnt = 0, perr_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at posedge+1; holds the pin for exactly one bit time.
  task automatic drive_bit(input logic b);
    rx = b;
    repeat (N) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    repeat (n) drive_bit(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_bad);
    int v;
    v = cyc + LAT;
    exp_busy[cyc + 2 + H] = 1'b1;
    if (stop) begin
      ev_byte[v]  = d;
      exp_busy[v] = 1'b0;
    end else begin
      ev_ferr[v] = 1'b1;
    end
    if (PARITY_ON && par_bad) ev_perr[v] = 1'b1;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PARITY_ON) drive_bit((^d) ^ par_bad);
    drive_bit(stop);
  endtask

  // Random ready source used during the randomized phase.
  initial begin
    rnd_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 rnd_ready = 1'($urandom_range(0, 1));
    end
  end

  // Reference model and per-cycle compare.
  initial begin
    logic       m_valid, m_ovr, hs;
    logic [7:0] m_data;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst_valid", bus.rx_valid, 0);
        chk("rst_data", bus.rx_data, 0);
        chk("rst_flags", {frame_err, parity_err, overrun, busy}, 0);
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_data  = 8'h00;
      end else begin
        chk("rx_valid", bus.rx_valid, m_valid);
        chk("rx_data", bus.rx_data, m_data);
        chk("frame_err", frame_err, ev_ferr.exists(cyc));
        chk("parity_err", parity_err, ev_perr.exists(cyc));
        chk("overrun", overrun, m_ovr);
        if (exp_busy.exists(cyc)) chk("busy", busy, exp_busy[cyc]);
        // Holding register for the next cycle.
        hs    = m_valid && bus.rx_ready;
        m_ovr = 1'b0;
        if (ev_byte.exists(cyc + 1)) begin
          if (!m_valid || hs) begin
            m_data  = ev_byte[cyc + 1];
            m_valid = 1'b1;
          end else begin
            m_ovr = 1'b1;
          end
        end else if (hs) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  // Transaction log and counters for the directed checks.
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.rx_valid && !prev) begin
          rises++;
          last_rise_cyc = cyc;
        end
        if (bus.rx_valid && bus.rx_ready) begin
          got.push_back(bus.rx_data);
          $display("[TB] cycle %0d: byte %02h accepted", cyc, bus.rx_data);
        end
        if (frame_err)  begin ferr_cnt++; $display("[TB] cycle %0d: frame error", cyc); end
        if (overrun)    begin ovr_cnt++;  $display("[TB] cycle %0d: overrun", cyc); end
        if (parity_err) begin perr_cnt++; $display("[TB] cycle %0d: parity error", cyc); end
      end
      prev = bus.rx_valid;
    end
  end

  initial begin
    int c, r0, f0, o0, p0, g0, gap;
    logic [7:0] msg [15];
    logic [7:0] d;
    logic stop, pb;
    string s;

    s = "Hello, World!";
    for (int i = 0; i < 13; i++) msg[i] = s[i];
    msg[13] = 8'h0D;
    msg[14] = 8'h0A;

    reset = 1'b1;
    rx = 1'b1;
    ready_mode = 1'b0;
    ready_val = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    idle_bits(2);

    // Single byte 0x57, ready high.
    c = cyc; r0 = rises; f0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'h57, 1'b1, 1'b0);
    idle_bits(1);
    chk("b57_pulses", rises - r0, 1);
    chk("b57_latency", last_rise_cyc - c, 155 + (PARITY_ON ? 16 : 0));
    chk("b57_data", got[got.size() - 1], 8'h57);
    chk("b57_noflags", (ferr_cnt - f0) + (ovr_cnt - o0), 0);

    // Back-to-back "Hello, World!" CR LF with no idle gap.
    g0 = got.size(); f0 = ferr_cnt; o0 = ovr_cnt;
    for (int i = 0; i < 15; i++) send_frame(msg[i], 1'b1, 1'b0);
    idle_bits(2);
    chk("hello_count", got.size() - g0, 15);
    for (int i = 0; i < 15; i++) chk("hello_byte", got[g0 + i], msg[i]);
    chk("hello_noflags", (ferr_cnt - f0) + (ovr_cnt - o0), 0);

    // Overrun: consumer stalled across two bytes.
    ready_val = 1'b0;
    o0 = ovr_cnt;
    send_frame(8'h41, 1'b1, 1'b0);
    send_frame(8'h42, 1'b1, 1'b0);
    idle_bits(2);
    chk("ovr_held_data", bus.rx_data, 8'h41);
    chk("ovr_held_valid", bus.rx_valid, 1);
    chk("ovr_pulses", ovr_cnt - o0, 1);
    ready_val = 1'b1;
    @(posedge clk);
    #1;
    chk("ovr_drained", bus.rx_valid, 0);
    chk("ovr_consumed", got[got.size() - 1], 8'h41);
    idle_bits(1);

    // 4-cycle glitch on the idle line.
    c = cyc; r0 = rises; f0 = ferr_cnt;
    exp_busy[c + 2 + H] = 1'b1;
    exp_busy[c + 3 + H] = 1'b0;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    idle_bits(2);
    chk("glitch_no_byte", rises - r0, 0);
    chk("glitch_no_ferr", ferr_cnt - f0, 0);

    // Stop bit forced low on 0x30.
    r0 = rises; f0 = ferr_cnt;
    send_frame(8'h30, 1'b0, 1'b0);
    idle_bits(2);
    chk("stop0_ferr", ferr_cnt - f0, 1);
    chk("stop0_no_byte", rises - r0, 0);

    // Break: line held low for 50 bit times.
    r0 = rises; f0 = ferr_cnt;
    send_frame(8'h00, 1'b0, 1'b0);
    repeat (50 - FRAME_BITS) drive_bit(1'b0);
    idle_bits(2);
    chk("break_ferr", ferr_cnt - f0, 1);
    chk("break_no_byte", rises - r0, 0);

    // Reset during data bit 3 of 0x55, then 0x7E.
    r0 = rises; f0 = ferr_cnt; o0 = ovr_cnt;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rx = 1'b0;
    repeat (H) @(posedge clk);
    #1;
    reset = 1'b1;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("inrst_data", bus.rx_data, 8'h00);
    chk("inrst_busy", busy, 0);
    reset = 1'b0;
    idle_bits(2);
    send_frame(8'h7E, 1'b1, 1'b0);
    idle_bits(2);
    chk("rst_one_byte", rises - r0, 1);
    chk("rst_byte", got[got.size() - 1], 8'h7E);
    chk("rst_noflags", (ferr_cnt - f0) + (ovr_cnt - o0), 0);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x57 has five ones, so the parity bit is 1.
    p0 = perr_cnt;
    send_frame(8'h57, 1'b1, 1'b0);
    idle_bits(1);
    chk("par_clean", perr_cnt - p0, 0);
    send_frame(8'h57, 1'b1, 1'b1);
    idle_bits(1);
    chk("par_err", perr_cnt - p0, 1);
    chk("par_err_data", got[got.size() - 1], 8'h57);
`endif

    // Randomized frames, gaps, stop errors, parity errors and ready.
    ready_mode = 1'b1;
    p0 = 0;
    for (int i = 0; i < 60; i++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      pb   = PARITY_ON && ($urandom_range(0, 3) == 0);
      gap  = $urandom_range(0, 2);
      send_frame(d, stop, pb);
      if (!stop && gap == 0) gap = 1;
      idle_bits(gap);
    end
    ready_mode = 1'b0;
    ready_val = 1'b1;
    idle_bits(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
